updown_counter_param: RTL
=========================

// Module: updown_counter_param
// PURPOSE
//  Parametrised up/down modulo counter; successor to the fixed 8-bit free-running up counter.
//  Adds configurable width and modulus, count enable, direction control, and synchronous parallel load.
//  Boundary mode is selectable: wrap or saturate. Registered event pulses and boundary flags are provided.
//  Used as a timer/index/address generator wherever a bounded count is required.
// PARAMETERS
//  WIDTH     8             count width in bits (>=1)
//  MAX_VAL   2**WIDTH-1    highest legal count; modulus = MAX_VAL+1 (must fit in WIDTH bits)
//  RST_VAL   0             count value after reset (must be <= MAX_VAL)
//  SATURATE  0             0 = wrap at boundaries, 1 = hold at boundaries
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous reset, active-high
//  en        in   1      count enable; count steps by 1 per enabled cycle
//  up_dn     in   1      1 = count up, 0 = count down
//  load      in   1      synchronous parallel load
//  load_val  in   WIDTH  value for load
//  count     out  WIDTH  registered count
//  wrap      out  1      registered 1-cycle pulse: count wrapped this edge (SATURATE=0 only)
//  sat       out  1      registered 1-cycle pulse: step blocked at a boundary (SATURATE=1 only)
//  at_max    out  1      combinational, count == MAX_VAL
//  at_min    out  1      combinational, count == 0
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Everything is sampled on the rising edge of clk. Priority: rst > load > en > hold.
//  - Reset: count=RST_VAL, wrap=0, sat=0 on the edge rst=1 is sampled. Reset mid-count aborts any pending pulse.
//  - Load: count = (load_val > MAX_VAL) ? MAX_VAL : load_val. Clamping is unsigned.
//    Load ignores en and up_dn. wrap=0 and sat=0 on a load edge.
//  - en=1 up, count<MAX_VAL: count+1. en=1 down, count>0: count-1. wrap=0, sat=0.
//  - Up at MAX_VAL:
//      SATURATE=0: count=0, wrap=1.
//      SATURATE=1: count holds MAX_VAL, sat=1.
//  - Down at 0:
//      SATURATE=0: count=MAX_VAL, wrap=1.
//      SATURATE=1: count holds 0, sat=1.
//  - en=0 and no load: count holds, wrap=0, sat=0.
//  - Pulses are high exactly one cycle, coincident with the new count value.
//    Back-to-back boundary steps give consecutive pulses; no stretching.
//  - Latency: count, wrap and sat update 1 cycle after the controlling inputs are sampled.
//    at_max and at_min are zero-latency decodes of count.
//  - Arithmetic is WIDTH-bit unsigned. The boundary compare occurs before increment, so there is no
//    WIDTH overflow when MAX_VAL = 2**WIDTH-1.
//  - Direction change mid-count takes effect on the next enabled edge, with no dead cycle.
//  - MAX_VAL=0 degenerate: count stays 0 and at_max=at_min=1.
//      Every enabled step gives wrap=1 (SATURATE=0) or sat=1 (SATURATE=1).
//  - Invalid parameters (MAX_VAL >= 2**WIDTH, RST_VAL > MAX_VAL) are rejected at elaboration
//    via generate-time $error.
// TESTING  (bench default WIDTH=8, MAX_VAL=9, RST_VAL=0; check 1ns after each edge)
//  1. rst=1 for 2 edges -> count=0, at_min=1, wrap=0, sat=0.
//     Then rst=0, en=1, up_dn=1 for 12 edges -> 1..9,0,1,2.
//     wrap=1 only on the 9->0 edge; at_max=1 while count=9.
//  2. From count=2, up_dn=0 for 4 edges -> 1,0,9,8. wrap=1 on the 0->9 edge only.
//     en=0 for 3 edges -> count holds 8.
//  3. load=1, load_val=5 with en=1, up_dn=1 -> count=5 (load wins).
//     Then load_val=200 -> count=9 (clamped). load with rst=1 -> count=0 (rst wins).
//  4. SATURATE=1 instance: count up from 7 for 4 edges -> 8,9,9,9, sat=1 on the last two edges.
//     Then down from 1 for 3 edges -> 0,0,0, sat=1 on the last two edges. wrap never asserts.
//  5. WIDTH=8, MAX_VAL=255 instance: load 253, up 4 edges -> FE,FF,00,01, wrap=1 on FF->00.
//     rst=1 mid-count -> 00 next edge, wrap=0.
//  6. Randomised en/up_dn/load for 2000 cycles against a reference model.
//     Check count, wrap, sat, at_max and at_min every cycle; print TEST PASSED/TEST FAILED.

Source files
------------

// File: rtl/updown_counter_param_if.sv
// ----------------------------------------------------------------------------
// updown_counter_param_if
//
// Purpose:
//   Bundles the control inputs and status outputs of updown_counter_param into
//   a single port. Clock and reset are not part of the bundle. They stay as
//   plain scalar ports on the counter.
//
// Signals (seen from the counter, i.e. the slave modport):
//   en        in   1      count enable, one step per enabled edge
//   up_dn     in   1      1 = count up, 0 = count down
//   load      in   1      synchronous parallel load
//   load_val  in   WIDTH  value to load (clamped to MAX_VAL by the counter)
//   count     out  WIDTH  registered count
//   wrap      out  1      registered one-cycle pulse, count wrapped this edge
//   sat       out  1      registered one-cycle pulse, step blocked at a boundary
//   at_max    out  1      count == MAX_VAL (combinational decode)
//   at_min    out  1      count == 0 (combinational decode)
//
// Modports:
//   master  drives the controls and observes the status (user side)
//   slave   receives the controls and drives the status (counter side)
// ----------------------------------------------------------------------------
interface updown_counter_param_if #(
  parameter int unsigned WIDTH = 8
);

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             sat;
  logic             at_max;
  logic             at_min;

  // The user side drives the controls and samples the status.
  modport master (
    output en,
    output up_dn,
    output load,
    output load_val,
    input  count,
    input  wrap,
    input  sat,
    input  at_max,
    input  at_min
  );

  // The counter side samples the controls and drives the status.
  modport slave (
    input  en,
    input  up_dn,
    input  load,
    input  load_val,
    output count,
    output wrap,
    output sat,
    output at_max,
    output at_min
  );

endinterface

// File: rtl/updown_counter_param.sv
// ----------------------------------------------------------------------------
// updown_counter_param
//
// Purpose:
//   Parametrised up/down modulo counter with count enable, direction control
//   and synchronous parallel load. It can either wrap or saturate at its
//   boundaries. It gives registered one-cycle event pulses (wrap / sat) and
//   combinational boundary flags (at_max / at_min). Use it as a timer, index
//   or address generator wherever a bounded count is needed.
//
// Parameters:
//   WIDTH     count width in bits (1..63)
//   MAX_VAL   highest legal count; the modulus is MAX_VAL+1
//   RST_VAL   count value after reset (must not exceed MAX_VAL)
//   SATURATE  0 = wrap at the boundaries, 1 = hold at the boundaries
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous reset, active-high
//   bus       slave modport of updown_counter_param_if:
//               en, up_dn, load, load_val in
//               count, wrap, sat, at_max, at_min out
//
// Behaviour summary:
//   Priority on each rising edge is rst > load > en > hold. A load clamps
//   load_val to MAX_VAL. An enabled step that would leave the range
//   [0, MAX_VAL] either wraps to the opposite boundary and pulses wrap, or
//   holds and pulses sat. All other edges clear both pulses.
// ----------------------------------------------------------------------------
module updown_counter_param #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RST_VAL  = 0,
  parameter bit              SATURATE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  updown_counter_param_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks. A counter whose maximum does not fit
  // in the count register, or whose reset value lies outside the legal range,
  // is meaningless. Such configurations are refused outright rather than
  // silently truncated.
  // --------------------------------------------------------------------------
  if (WIDTH < 1 || WIDTH > 63) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be in the range 1..63");
  end

  if (MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("updown_counter_param: MAX_VAL does not fit in WIDTH bits");
  end

  if (RST_VAL > MAX_VAL) begin : g_bad_rst
    $error("updown_counter_param: RST_VAL exceeds MAX_VAL");
  end

  // --------------------------------------------------------------------------
  // Parameters narrowed to the count width so that every compare and
  // assignment below is a plain WIDTH-bit unsigned operation.
  // --------------------------------------------------------------------------
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ZERO_C = '0;
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

  // --------------------------------------------------------------------------
  // State and next-state signals.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             sat_q;

  logic [WIDTH-1:0] count_next;
  logic             wrap_next;
  logic             sat_next;

  logic [WIDTH-1:0] load_clamped;
  logic             hit_max;
  logic             hit_min;

  // --------------------------------------------------------------------------
  // Boundary decodes of the current count. They feed both the step decision
  // and the at_max / at_min outputs, so the flags always agree with the
  // boundary behaviour. When MAX_VAL is 0 both are true at once, and every
  // enabled step is a boundary step.
  // --------------------------------------------------------------------------
  assign hit_max = (count_q == MAX_C);
  assign hit_min = (count_q == ZERO_C);

  // --------------------------------------------------------------------------
  // Load-value clamp. The compare is unsigned and WIDTH bits wide, so a value
  // above MAX_VAL (but still representable) is pulled down to MAX_VAL.
  // --------------------------------------------------------------------------
  assign load_clamped = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;

  // --------------------------------------------------------------------------
  // Next-state logic. Load takes precedence over counting, and reset is
  // handled in the register process so it overrides everything here.
  // Boundaries are tested before any increment or decrement. This is why
  // MAX_VAL = 2**WIDTH-1 never needs a WIDTH+1-bit adder and never overflows.
  // The pulses default to 0, so they can only last the single cycle in which
  // the boundary step happens. Back-to-back boundary steps re-assert them on
  // each edge.
  // --------------------------------------------------------------------------
  always_comb begin
    count_next = count_q;
    wrap_next  = 1'b0;
    sat_next   = 1'b0;

    if (bus.load) begin
      count_next = load_clamped;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (hit_max) begin
          if (SATURATE) begin
            sat_next   = 1'b1;
          end else begin
            count_next = ZERO_C;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = count_q + ONE_C;
        end
      end else begin
        if (hit_min) begin
          if (SATURATE) begin
            sat_next   = 1'b1;
          end else begin
            count_next = MAX_C;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = count_q - ONE_C;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register with synchronous reset. Reset also clears any pulse that
  // would otherwise have been produced on the same edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_C;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_next;
      wrap_q  <= wrap_next;
      sat_q   <= sat_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. count, wrap and sat come straight from registers. The boundary
  // flags are zero-latency decodes of the registered count.
  // --------------------------------------------------------------------------
  assign bus.count  = count_q;
  assign bus.wrap   = wrap_q;
  assign bus.sat    = sat_q;
  assign bus.at_max = hit_max;
  assign bus.at_min = hit_min;

endmodule
